cpu_mc: RTL and testbench
=========================

Name: cpu_mc

Overview:
- Parametrised multicycle accumulator CPU, successor of the current IN/OUT-only core.
- Adds arithmetic (MOV, ADD, SUB, MUL), three-operand direct/indirect addressing for every operand, valid/ready handshakes on the I/O ports, and an explicit halt/error status.
- Sits between a single-port synchronous memory (program and data) and the board I/O.

Parameters:
ADDR_WIDTH, 6, memory address, PC and SP width
DATA_WIDTH, 16, memory word and datapath width (>=16)
START_PC, 8, PC value loaded at reset
SP_INIT, 2**ADDR_WIDTH-1, SP value loaded at reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
mem  in  DATA_WIDTH  memory read data
in  in  DATA_WIDTH  input word
in_valid  in  1  input word present
in_ready  out  1  CPU consumes input this cycle
we  out  1  memory write enable
addr  out  ADDR_WIDTH  memory address (MAR)
data  out  DATA_WIDTH  memory write data (MDR)
out  out  DATA_WIDTH  output word
out_valid  out  1  one-cycle strobe: out updated
pc  out  ADDR_WIDTH  program counter
sp  out  ADDR_WIDTH  stack pointer (held, reserved for later)
halted  out  1  CPU stopped
error  out  1  illegal opcode seen

Behaviour:
- Reset: asynchronous, active-low. pc=START_PC, sp=SP_INIT, addr=0, data=0, out=0, we=0, in_ready=0, out_valid=0, halted=0, error=0, state=FETCH. Reset mid-instruction aborts it; no partial write completes after rst_n rises.
- Instruction word:
  - [15:12] opcode.
  - Operand X=[11:8], Y=[7:4], Z=[3:0]. Each field is {indirect bit, 3-bit address}.
  - Direct: operand is mem[addr]. Indirect: operand is mem[mem[addr][ADDR_WIDTH-1:0]].
- Memory read timing: addr is registered. mem is valid and sampled 2 cycles after the cycle that loads addr (load, wait, latch). An indirect operand costs one extra read.
- Memory write timing: we=1 for exactly one cycle, with addr/data already stable. addr/data are held one further cycle after we falls.
- Fetch sequence: F0 (addr<=pc, pc<=pc+1), F1 (wait), F2 (latch mem into IR), DEC.
- PC wraps modulo 2**ADDR_WIDTH.
- Opcodes:
  - MOV=0: X<=Y.
  - ADD=1: X<=Y+Z.
  - SUB=2: X<=Y-Z.
  - MUL=3: X<=low DATA_WIDTH bits of Y*Z.
  - IN=7: X<=in.
  - OUT=8: out<=X.
  - STOP=F: halted.
  - All other opcodes: error.
- Arithmetic: unsigned, modulo 2**DATA_WIDTH. No flags. Z is ignored by MOV, IN and OUT.
- Operand read order is Y then Z; X's effective address is resolved last, before the write.
- IN handshake:
  - State IN_WAIT holds in_ready=1 until in_valid=1.
  - The transfer completes on the cycle both are high.
  - in is captured that cycle; in_ready drops the next cycle.
  - No timeout.
- OUT:
  - out is loaded with X; out_valid=1 for exactly the following cycle.
  - out holds its value until the next OUT or reset.
- STOP: halted=1. The CPU stays in HALT with no further memory accesses; pc is frozen at the address after STOP.
- Error: error=1 and halted=1, and out=all-ones. The state is sticky until reset.
- Aliasing: if X's effective address equals Y's or Z's, the write uses the already-latched operand values (read-before-write).
- Latency, cycles from F0 to the next F0:
  - ADD/SUB/MUL with all operands direct: 3 fetch + 1 DEC + 3 (Y) + 3 (Z) + 1 EXEC + 2 (write) = 13.
  - Each indirect operand adds 3.
  - MOV, all direct: 10.
  - IN: 3 fetch + 1 DEC + k wait + 1 capture + 2 write, where k is the number of in_valid=0 cycles.

Test Plan:
- Reset with START_PC=8 -> pc=8, sp=63, all status/strobe outputs 0. Release -> first read addr=8 two cycles before IR latch.
- mem[8]=0x1123 (ADD X=1,Y=2,Z=3), mem[2]=5, mem[3]=7 -> write addr=1 data=12, we high exactly 1 cycle, next fetch at pc=9 after 13 cycles.
- SUB wrap: mem[2]=3, mem[3]=5 -> X=0xFFFE. MUL 0x0100*0x0100 -> X=0x0000.
- IN indirect 0x7A00 with mem[2]=0x0005, in_valid held low 4 cycles then in=0x00AB -> single in_ready/in_valid overlap, mem[5]=0x00AB.
- OUT 0x8300 with mem[3]=0x1234 -> out=0x1234, out_valid one cycle. Followed by STOP 0xF000 -> halted=1, no further addr changes.
- Opcode 0x5 -> error=1, halted=1, out=0xFFFF. Assert rst_n low mid-ADD write -> we=0 immediately, no memory update, pc=START_PC.

Source files
------------

// File: rtl/cpu_mc_if.sv
// Memory, board I/O and status bundle between cpu_mc (master) and its environment (slave).
interface cpu_mc_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] mem_i;
  logic [DATA_WIDTH-1:0] in_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [DATA_WIDTH-1:0] out_o;
  logic                  out_valid_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic [ADDR_WIDTH-1:0] sp_o;
  logic                  halted_o;
  logic                  error_o;

  modport master (
    input  mem_i, in_i, in_valid_i,
    output in_ready_o, we_o, addr_o, data_o, out_o, out_valid_o,
           pc_o, sp_o, halted_o, error_o
  );

  modport slave (
    output mem_i, in_i, in_valid_i,
    input  in_ready_o, we_o, addr_o, data_o, out_o, out_valid_o,
           pc_o, sp_o, halted_o, error_o
  );
endinterface

// File: rtl/cpu_mc.sv
// Multicycle three-operand accumulator CPU: fetch/decode, Y/Z operand reads with optional
// indirection, X write-back, valid/ready input port, strobed output port, halt and error status.
module cpu_mc #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = ADDR_WIDTH'(8),
  parameter logic [ADDR_WIDTH-1:0] SP_INIT    = ADDR_WIDTH'((2**ADDR_WIDTH) - 1)
) (
  input logic      clk,
  input logic      rst_n,
  cpu_mc_if.master bus
);

  typedef enum logic [3:0] {
    S_F0 = 4'd0, S_F1 = 4'd1, S_F2 = 4'd2, S_DEC = 4'd3,
    S_RA = 4'd4, S_RW = 4'd5, S_RL = 4'd6, S_EXEC = 4'd7,
    S_W0 = 4'd8, S_W1 = 4'd9, S_IN_WAIT = 4'd10, S_HALT = 4'd11
  } state_t;

  // SEL_A/SEL_B: read an operand value; SEL_X: read the pointer of an indirect destination.
  typedef enum logic [1:0] {SEL_A = 2'd0, SEL_B = 2'd1, SEL_X = 2'd2} sel_t;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_STOP = 4'hF;

  state_t                state_q, state_d;
  sel_t                  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, sp_q, sp_d, addr_q, addr_d, ea_q, ea_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, out_q, out_d, opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [15:0]           ir_q, ir_d;
  logic                  we_q, we_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                  halted_q, halted_d, error_q, error_d, ind_q, ind_d;
  logic [3:0]            opc_s, x_s, y_s, z_s;
  logic [DATA_WIDTH-1:0] alu_s, wval_s;
  logic                  is_alu_s, start_wr_s;

  function automatic logic [ADDR_WIDTH-1:0] fld_addr(input logic [2:0] f);
    fld_addr = {{(ADDR_WIDTH-3){1'b0}}, f};
  endfunction

  assign opc_s    = ir_q[15:12];
  assign x_s      = ir_q[11:8];
  assign y_s      = ir_q[7:4];
  assign z_s      = ir_q[3:0];
  assign is_alu_s = (opc_s == OP_ADD) || (opc_s == OP_SUB) || (opc_s == OP_MUL);

  always_comb begin
    alu_s = opa_q;
    case (opc_s)
      OP_ADD:  alu_s = opa_q + opb_q;
      OP_SUB:  alu_s = opa_q - opb_q;
      OP_MUL:  alu_s = opa_q * opb_q;
      default: alu_s = opa_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    in_ready_d  = in_ready_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    error_d     = error_q;
    ir_d        = ir_q;
    ea_d        = ea_q;
    ind_d       = ind_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    start_wr_s  = 1'b0;
    wval_s      = alu_s;
    case (state_q)
      S_F0: begin
        addr_d  = pc_q;
        pc_d    = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        state_d = S_F1;
      end
      S_F1: state_d = S_F2;
      S_F2: begin
        ir_d    = bus.mem_i[15:0];
        state_d = S_DEC;
      end
      S_DEC: begin
        case (opc_s)
          OP_MOV, OP_ADD, OP_SUB, OP_MUL: begin
            sel_d   = SEL_A;
            ea_d    = fld_addr(y_s[2:0]);
            ind_d   = y_s[3];
            state_d = S_RA;
          end
          OP_OUT: begin
            sel_d   = SEL_A;
            ea_d    = fld_addr(x_s[2:0]);
            ind_d   = x_s[3];
            state_d = S_RA;
          end
          OP_IN: begin
            in_ready_d = 1'b1;
            state_d    = S_IN_WAIT;
          end
          OP_STOP: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            error_d  = 1'b1;
            halted_d = 1'b1;
            out_d    = {DATA_WIDTH{1'b1}};
            state_d  = S_HALT;
          end
        endcase
      end
      S_RA: begin
        addr_d  = ea_q;
        state_d = S_RW;
      end
      S_RW: state_d = S_RL;
      S_RL: begin
        if (sel_q == SEL_X) begin
          addr_d  = bus.mem_i[ADDR_WIDTH-1:0];
          data_d  = res_q;
          we_d    = 1'b1;
          state_d = S_W0;
        end else if (ind_q) begin
          ea_d    = bus.mem_i[ADDR_WIDTH-1:0];
          ind_d   = 1'b0;
          state_d = S_RA;
        end else if (sel_q == SEL_A) begin
          opa_d = bus.mem_i;
          if (is_alu_s) begin
            sel_d   = SEL_B;
            ea_d    = fld_addr(z_s[2:0]);
            ind_d   = z_s[3];
            state_d = S_RA;
          end else begin
            state_d = S_EXEC;
          end
        end else begin
          opb_d   = bus.mem_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opc_s == OP_OUT) begin
          out_d       = opa_q;
          out_valid_d = 1'b1;
          state_d     = S_F0;
        end else begin
          start_wr_s = 1'b1;
        end
      end
      S_IN_WAIT: begin
        if (bus.in_valid_i) begin
          in_ready_d = 1'b0;
          wval_s     = bus.in_i;
          start_wr_s = 1'b1;
        end else begin
          state_d = S_IN_WAIT;
        end
      end
      S_W0:    state_d = S_W1;
      S_W1:    state_d = S_F0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_F0;
    endcase

    // An indirect destination detours through one pointer read before the write.
    if (start_wr_s) begin
      if (x_s[3]) begin
        res_d   = wval_s;
        sel_d   = SEL_X;
        ea_d    = fld_addr(x_s[2:0]);
        ind_d   = 1'b0;
        state_d = S_RA;
      end else begin
        addr_d  = fld_addr(x_s[2:0]);
        data_d  = wval_s;
        we_d    = 1'b1;
        state_d = S_W0;
      end
    end else begin
      res_d = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_F0;
      sel_q       <= SEL_A;
      pc_q        <= START_PC;
      sp_q        <= SP_INIT;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      ea_q        <= {ADDR_WIDTH{1'b0}};
      data_q      <= {DATA_WIDTH{1'b0}};
      out_q       <= {DATA_WIDTH{1'b0}};
      opa_q       <= {DATA_WIDTH{1'b0}};
      opb_q       <= {DATA_WIDTH{1'b0}};
      res_q       <= {DATA_WIDTH{1'b0}};
      ir_q        <= 16'h0000;
      we_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
      ind_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      addr_q      <= addr_d;
      ea_q        <= ea_d;
      data_q      <= data_d;
      out_q       <= out_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      ir_q        <= ir_d;
      we_q        <= we_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      error_q     <= error_d;
      ind_q       <= ind_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.we_o        = we_q;
  assign bus.addr_o      = addr_q;
  assign bus.data_o      = data_q;
  assign bus.out_o       = out_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.pc_o        = pc_q;
  assign bus.sp_o        = sp_q;
  assign bus.halted_o    = halted_q;
  assign bus.error_o     = error_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: synchronous memory model, write/output scoreboards, instruction vector
// table, and hand-written IN/OUT, error and reset-during-write sequences.
module tb_cpu_mc;
  localparam int AW = 6;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_mc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cpu_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_PC(6'd8), .SP_INIT(6'd63)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [15:0]      instr;
    logic [4:0][5:0]  ia;
    logic [4:0][15:0] iv;
    logic [5:0]       wa;
    logic [15:0]      wd;
    int               lat;
  } vec_t;

  logic [DW-1:0] mem      [0:63];
  logic [DW-1:0] init_mem [0:63];
  wr_t           wq [$];
  logic [15:0]   oq [$];
  int            checks = 0;
  int            failures = 0;
  int            wecnt = 0;
  int            ovcnt = 0;
  int            ovl = 0;
  logic          prev_we = 1'b0;
  logic [5:0]    last_a = 6'd0;
  logic [15:0]   last_d = 16'd0;
  vec_t          vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act);
    checks   = checks + 1;
    failures = failures + 1;
    $display("FAIL %s actual=%h expected=none", name, act);
  endtask

  // Memory loads its image while reset is held; a write still lands if we is high at the edge.
  always @(posedge clk) begin
    bus.mem_i <= mem[bus.addr_o];
    if (!rst_n) mem <= init_mem;
    if (bus.we_o) mem[bus.addr_o] <= bus.data_o;
  end

  always @(negedge clk) begin
    if (rst_n && bus.we_o) begin
      if (wq.size() == 0) begin
        report_fail("unexpected_write", 32'(bus.addr_o));
      end else begin
        chk("wr_addr", 32'(bus.addr_o), 32'(wq[0].a));
        chk("wr_data", 32'(bus.data_o), 32'(wq[0].d));
        void'(wq.pop_front());
      end
    end
    if (rst_n && prev_we && !bus.we_o) begin
      chk("wr_hold_addr", 32'(bus.addr_o), 32'(last_a));
      chk("wr_hold_data", 32'(bus.data_o), 32'(last_d));
    end
    prev_we <= bus.we_o && rst_n;
    last_a  <= bus.addr_o;
    last_d  <= bus.data_o;
    if (bus.we_o) wecnt <= wecnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o) begin
      if (oq.size() == 0) begin
        report_fail("unexpected_out", 32'(bus.out_o));
      end else begin
        chk("out_val", 32'(bus.out_o), 32'(oq[0]));
        void'(oq.pop_front());
      end
      ovcnt <= ovcnt + 1;
    end
    if (rst_n && bus.in_ready_o && bus.in_valid_i) ovl <= ovl + 1;
  end

  task automatic hold_reset();
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_i = 16'h0000;
    for (int i = 0; i < 64; i++) init_mem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_prog(output int t8, output int t9);
    t8 = -1;
    t9 = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.addr_o == 6'd8 && t8 < 0) t8 = i;
      if (bus.addr_o == 6'd9 && t9 < 0) t9 = i;
      if (bus.halted_o) break;
    end
    if (!bus.halted_o) report_fail("halt_timeout", 32'(bus.pc_o));
  endtask

  task automatic check_frozen(input string name);
    logic [5:0] a0;
    logic [5:0] p0;
    a0 = bus.addr_o;
    p0 = bus.pc_o;
    repeat (5) @(posedge clk);
    #1;
    chk({name, "_addr_frozen"}, 32'(bus.addr_o), 32'(a0));
    chk({name, "_pc_frozen"}, 32'(bus.pc_o), 32'(p0));
  endtask

  initial begin
    int t8, t9, w0, o0, l0, rdy_at;

    vecs[0] = '{instr:16'h1123, ia:{6'd63, 6'd63, 6'd63, 6'd3, 6'd2},
                iv:{16'd0, 16'd0, 16'd0, 16'd7, 16'd5}, wa:6'd1, wd:16'd12, lat:13};
    vecs[1] = '{instr:16'h2123, ia:{6'd63, 6'd63, 6'd63, 6'd3, 6'd2},
                iv:{16'd0, 16'd0, 16'd0, 16'd5, 16'd3}, wa:6'd1, wd:16'hFFFE, lat:13};
    vecs[2] = '{instr:16'h3123, ia:{6'd63, 6'd63, 6'd63, 6'd3, 6'd2},
                iv:{16'd0, 16'd0, 16'd0, 16'h0100, 16'h0100}, wa:6'd1, wd:16'h0000, lat:13};
    vecs[3] = '{instr:16'h0140, ia:{6'd63, 6'd63, 6'd63, 6'd63, 6'd4},
                iv:{16'd0, 16'd0, 16'd0, 16'd0, 16'hBEEF}, wa:6'd1, wd:16'hBEEF, lat:10};
    vecs[4] = '{instr:16'h11A3, ia:{6'd63, 6'd63, 6'd3, 6'd5, 6'd2},
                iv:{16'd0, 16'd0, 16'd7, 16'd100, 16'd5}, wa:6'd1, wd:16'd107, lat:16};
    vecs[5] = '{instr:16'h2923, ia:{6'd63, 6'd63, 6'd3, 6'd2, 6'd1},
                iv:{16'd0, 16'd0, 16'd4, 16'd10, 16'd6}, wa:6'd6, wd:16'd6, lat:16};
    vecs[6] = '{instr:16'h1112, ia:{6'd63, 6'd63, 6'd63, 6'd2, 6'd1},
                iv:{16'd0, 16'd0, 16'd0, 16'd4, 16'd3}, wa:6'd1, wd:16'd7, lat:13};
    vecs[7] = '{instr:16'h3ABC, ia:{6'd14, 6'd13, 6'd4, 6'd3, 6'd2},
                iv:{16'd5, 16'd3, 16'd14, 16'd13, 16'h0011}, wa:6'd17, wd:16'd15, lat:22};

    hold_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc_o), 32'd8);
    chk("rst_sp", 32'(bus.sp_o), 32'd63);
    chk("rst_addr_data", {10'd0, bus.addr_o, bus.data_o}, 32'd0);
    chk("rst_out", 32'(bus.out_o), 32'd0);
    chk("rst_status", {27'd0, bus.we_o, bus.in_ready_o, bus.out_valid_o, bus.halted_o, bus.error_o}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      hold_reset();
      init_mem[8] = vecs[v].instr;
      init_mem[9] = 16'hF000;
      for (int k = 0; k < 5; k++) init_mem[vecs[v].ia[k]] = vecs[v].iv[k];
      wq.push_back('{a:vecs[v].wa, d:vecs[v].wd});
      w0 = wecnt;
      release_reset();
      run_prog(t8, t9);
      chk($sformatf("v%0d_first_fetch", v), 32'(t8), 32'd0);
      chk($sformatf("v%0d_latency", v), 32'(t9 - t8), 32'(vecs[v].lat));
      chk($sformatf("v%0d_we_cycles", v), 32'(wecnt - w0), 32'd1);
      chk($sformatf("v%0d_mem", v), 32'(mem[vecs[v].wa]), 32'(vecs[v].wd));
      chk($sformatf("v%0d_pc", v), 32'(bus.pc_o), 32'd10);
      chk($sformatf("v%0d_err", v), {30'd0, bus.halted_o, bus.error_o}, 32'd2);
    end

    // IN through an indirect destination, then OUT of the stored word, then STOP.
    hold_reset();
    init_mem[8]  = 16'h7A00;
    init_mem[9]  = 16'h8500;
    init_mem[10] = 16'hF000;
    init_mem[2]  = 16'h0005;
    wq.push_back('{a:6'd5, d:16'h00AB});
    oq.push_back(16'h00AB);
    w0 = wecnt; o0 = ovcnt; l0 = ovl;
    release_reset();
    t8 = -1; t9 = -1; rdy_at = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.addr_o == 6'd8 && t8 < 0) t8 = i;
      if (bus.addr_o == 6'd9 && t9 < 0) t9 = i;
      if (bus.in_ready_o && rdy_at < 0) rdy_at = i;
      if (rdy_at >= 0 && i == rdy_at + 5) chk("in_ready_drop", 32'(bus.in_ready_o), 32'd0);
      if (rdy_at >= 0 && i == rdy_at + 4) begin
        bus.in_valid_i = 1'b1;
        bus.in_i = 16'h00AB;
      end else begin
        bus.in_valid_i = 1'b0;
        bus.in_i = 16'h5555;
      end
      if (bus.halted_o) break;
    end
    if (!bus.halted_o) report_fail("in_halt_timeout", 32'(bus.pc_o));
    chk("in_latency", 32'(t9 - t8), 32'd14);
    chk("in_overlap", 32'(ovl - l0), 32'd1);
    chk("in_mem5", 32'(mem[5]), 32'h00AB);
    chk("in_we_cycles", 32'(wecnt - w0), 32'd1);
    chk("in_out_pulses", 32'(ovcnt - o0), 32'd1);
    chk("in_out_hold", 32'(bus.out_o), 32'h00AB);
    chk("in_pc", 32'(bus.pc_o), 32'd11);

    // OUT direct followed by STOP.
    hold_reset();
    init_mem[8] = 16'h8300;
    init_mem[9] = 16'hF000;
    init_mem[3] = 16'h1234;
    oq.push_back(16'h1234);
    w0 = wecnt; o0 = ovcnt;
    release_reset();
    run_prog(t8, t9);
    chk("out_pulses", 32'(ovcnt - o0), 32'd1);
    chk("out_hold", 32'(bus.out_o), 32'h1234);
    chk("out_no_write", 32'(wecnt - w0), 32'd0);
    chk("stop_pc", 32'(bus.pc_o), 32'd10);
    chk("stop_status", {30'd0, bus.halted_o, bus.error_o}, 32'd2);
    check_frozen("stop");

    // Illegal opcode.
    hold_reset();
    init_mem[8] = 16'h5000;
    w0 = wecnt; o0 = ovcnt;
    release_reset();
    run_prog(t8, t9);
    chk("err_status", {30'd0, bus.halted_o, bus.error_o}, 32'd3);
    chk("err_out", 32'(bus.out_o), 32'hFFFF);
    chk("err_pc", 32'(bus.pc_o), 32'd9);
    chk("err_quiet", 32'((wecnt - w0) + (ovcnt - o0)), 32'd0);
    check_frozen("err");
    chk("err_sticky", {30'd0, bus.halted_o, bus.error_o}, 32'd3);

    // Reset asserted while the ADD write strobe is up.
    hold_reset();
    init_mem[8] = 16'h1123;
    init_mem[2] = 16'd5;
    init_mem[3] = 16'd7;
    release_reset();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.we_o) break;
    end
    if (!bus.we_o) report_fail("rst_we_timeout", 32'(bus.pc_o));
    rst_n = 1'b0;
    #1;
    chk("rstw_we", 32'(bus.we_o), 32'd0);
    chk("rstw_pc", 32'(bus.pc_o), 32'd8);
    @(posedge clk);
    #1;
    chk("rstw_mem1", 32'(mem[1]), 32'd0);

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("oq_empty", 32'(oq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
